ddr_cmd_ctrl: RTL
=================

DDR_CMD_CTRL -- requirements
Module: ddr_cmd_ctrl

Interface
REQ-001 SHALL have parameters: TRCD=3 (ACT to READ/WRITE clocks); CL=2 (CAS latency clocks); BL=4 (burst length, beats); TWR=2 (write recovery clocks); TRP=3 (precharge clocks); TRFC=10 (refresh cycle clocks); TREF=780 (refresh interval clocks).
REQ-002 SHALL have clk  input  1  sole clock; all logic samples on its rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have req_valid  input  1  host request present.
REQ-005 SHALL have req_ready  output  1  controller accepts the request this cycle.
REQ-006 SHALL have req_cmd  input  2  host command: NOP=0, READA=1, WRITEA=2, 3 reserved.
REQ-007 SHALL have req_addr  input  25  {ba[24:23], row[22:10], col[9:0]}.
REQ-008 SHALL have cs_n, ras_n, cas_n, we_n  output  1 each  SDRAM command pins.
REQ-009 SHALL have ba  output  2  bank address; a  output  13  row/column address.
REQ-010 SHALL have rd_window  output  1  read data expected on DQ this cycle.
REQ-011 SHALL have wr_window  output  1  write data/DM to be driven this cycle.
REQ-012 SHALL have ref_busy  output  1  auto-refresh in progress.

Function
REQ-013 SHALL encode commands as {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACT=0011, READ=0101, WRITE=0100, AREF=0001; exactly one command per cycle, NOP when idle.
REQ-014 SHALL use FSM states IDLE, ACT, WAIT_RCD, RW, WAIT_DONE, REF, WAIT_RFC.
REQ-015 SHALL assert req_ready only in IDLE with no refresh pending; a request is accepted when req_valid && req_ready.
REQ-016 SHALL treat accepted NOP or reserved req_cmd as consumed without issuing any SDRAM command; FSM stays IDLE.
REQ-017 SHALL register req_addr and req_cmd at acceptance; later input changes have no effect on the transaction.
REQ-018 SHALL issue ACT one cycle after acceptance with ba=addr[24:23], a=row.
REQ-019 SHALL issue READ or WRITE exactly TRCD cycles after ACT, with a[9:0]=col, a[10]=1 (auto-precharge), a[12:11]=0, same ba.
REQ-020 SHALL assert rd_window for BL/2 consecutive cycles starting CL cycles after READ.
REQ-021 SHALL assert wr_window for BL/2 consecutive cycles starting 1 cycle after WRITE.
REQ-022 SHALL return to IDLE, with req_ready high, at READ+CL+BL/2+TRP cycles or WRITE+1+BL/2+TWR+TRP cycles.
REQ-023 SHALL run a refresh timer counting TREF cycles; on expiry, set ref_pending and reload.
REQ-024 SHALL give ref_pending priority over req_valid in the same cycle; req_ready is low while pending.
REQ-025 SHALL issue AREF the cycle after IDLE is reached with ref_pending, clear ref_pending, and hold ref_busy high from AREF through TRFC-1 following NOP cycles.
REQ-026 SHALL keep one pending refresh at most; a timer expiry while pending is absorbed (saturating).
REQ-027 SHALL keep the refresh timer running during transactions and refresh.

Reset
REQ-028 SHALL, while rst is high, force state IDLE, command NOP, ba=0, a=0, req_ready=0, rd_window=0, wr_window=0, ref_busy=0, ref_pending=0, and refresh timer=TREF-1.
REQ-029 SHALL abort any in-flight transaction or refresh on mid-operation reset, with no further command issued.
REQ-030 SHALL assert req_ready in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the req_cmd enum, SDRAM command encodings and default timing constants in shared package ddr_ctrl_pkg.
REQ-032 SHALL implement the refresh timer and pending flag in sub-module ddr_ref_timer.

Verification
REQ-033 SHALL test READA: accept at cycle 0, addr={2'd1,13'h0A5,10'h3C} -> ACT(ba=1,a=0x0A5) at 1; READ(a=0x43C) at 4; rd_window at 6-7; req_ready at 11.
REQ-034 SHALL test WRITEA with the same address -> WRITE at 4 with a[10]=1; wr_window at 5-6; req_ready at 12.
REQ-035 SHALL test refresh with no traffic -> AREF at cycle TREF after reset release; ref_busy high for 10 cycles; req_ready low during refresh.
REQ-036 SHALL test req_valid high on the cycle ref_pending sets -> AREF first; request accepted only after TRFC completes.
REQ-037 SHALL test rst asserted at cycle 5 of a READA -> NOP next cycle, all outputs at reset values, no rd_window.
REQ-038 SHALL test back-to-back WRITEA x4, incremental addresses -> four ACT/WRITE pairs 12 cycles apart; a[10]=1 each time.

Source files
------------

// File: rtl/ddr_ctrl_pkg.sv
// Shared types and constants for the SDRAM command controller:
// host command enum, SDRAM pin encodings, FSM states and default timings.
package ddr_ctrl_pkg;

  typedef enum logic [1:0] {
    REQ_NOP    = 2'd0,
    REQ_READA  = 2'd1,
    REQ_WRITEA = 2'd2,
    REQ_RSVD   = 2'd3
  } req_cmd_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] SD_NOP   = 4'b0111;
  localparam logic [3:0] SD_ACT   = 4'b0011;
  localparam logic [3:0] SD_READ  = 4'b0101;
  localparam logic [3:0] SD_WRITE = 4'b0100;
  localparam logic [3:0] SD_AREF  = 4'b0001;

  localparam int DEF_TRCD = 3;
  localparam int DEF_CL   = 2;
  localparam int DEF_BL   = 4;
  localparam int DEF_TWR  = 2;
  localparam int DEF_TRP  = 3;
  localparam int DEF_TRFC = 10;
  localparam int DEF_TREF = 780;

  typedef enum logic [2:0] {
    IDLE,
    ACT,
    WAIT_RCD,
    RW,
    WAIT_DONE,
    REF,
    WAIT_RFC
  } state_e;

  // Column address with A10 set so the bank auto-precharges after the burst.
  function automatic logic [12:0] col_ap_addr(input logic [9:0] col);
    return {2'b00, 1'b1, col};
  endfunction

endpackage

// File: rtl/ddr_ref_timer.sv
// Free-running refresh interval timer with a single saturating pending flag.
module ddr_ref_timer
  import ddr_ctrl_pkg::*;
#(
  parameter int TREF = DEF_TREF
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_ack,
  output logic ref_due
);

  localparam int            TW     = $clog2(TREF + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TREF - 1);

  logic [TW-1:0] timer;
  logic          ref_pending;
  logic          expire;

  // The expiring cycle already counts as a request so AREF lands exactly TREF
  // cycles after the interval starts.
  assign expire  = (timer == '0);
  assign ref_due = ref_pending | expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= RELOAD;
      ref_pending <= 1'b0;
    end else begin
      timer       <= expire ? RELOAD : timer - TW'(1);
      ref_pending <= !ref_ack && (ref_pending || expire);
    end
  end

endmodule

// File: rtl/ddr_cmd_ctrl.sv
// Single-transaction SDRAM command sequencer: ACT, auto-precharge READ/WRITE,
// data window strobes and periodic auto-refresh.
module ddr_cmd_ctrl
  import ddr_ctrl_pkg::*;
#(
  parameter int TRCD = DEF_TRCD,
  parameter int CL   = DEF_CL,
  parameter int BL   = DEF_BL,
  parameter int TWR  = DEF_TWR,
  parameter int TRP  = DEF_TRP,
  parameter int TRFC = DEF_TRFC,
  parameter int TREF = DEF_TREF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [24:0] req_addr,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] a,
  output logic        rd_window,
  output logic        wr_window,
  output logic        ref_busy
);

  localparam int CW = 8;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] RCD_LAST = CW'(TRCD - 1);
  localparam logic [CW-1:0] RFC_LAST = CW'(TRFC - 1);
  // WAIT_DONE offsets are counted from the READ/WRITE cycle.
  localparam logic [CW-1:0] RD_FIRST = CW'(CL);
  localparam logic [CW-1:0] RD_LAST  = CW'(CL + BL/2 - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(BL/2);
  localparam logic [CW-1:0] RD_END   = CW'(CL + BL/2 + TRP - 1);
  localparam logic [CW-1:0] WR_END   = CW'(BL/2 + TWR + TRP);

  state_e        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [24:0]   addr_q;
  req_cmd_e      cmd_q;
  logic [3:0]    sd_cmd;
  logic          ref_due;
  logic          ref_ack;
  logic          accept;
  logic          is_read;

  ddr_ref_timer #(.TREF(TREF)) u_ref_timer (
    .clk     (clk),
    .rst     (rst),
    .ref_ack (ref_ack),
    .ref_due (ref_due)
  );

  assign accept  = req_valid && req_ready;
  assign is_read = (cmd_q == REQ_READA);
  assign {cs_n, ras_n, cas_n, we_n} = sd_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      cmd_q  <= REQ_NOP;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q <= req_addr;
        cmd_q  <= req_cmd_e'(req_cmd);
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sd_cmd     = SD_NOP;
    ba         = '0;
    a          = '0;
    rd_window  = 1'b0;
    wr_window  = 1'b0;
    ref_busy   = 1'b0;
    req_ready  = 1'b0;
    ref_ack    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !ref_due && !rst;
        if (ref_due) begin
          ref_ack    = 1'b1;
          state_next = REF;
        end else if (req_valid && (req_cmd == REQ_READA || req_cmd == REQ_WRITEA)) begin
          state_next = ACT;
        end
      end
      ACT: begin
        sd_cmd = SD_ACT;
        ba     = addr_q[24:23];
        a      = addr_q[22:10];
        if (TRCD <= 1) begin
          state_next = RW;
        end else begin
          state_next = WAIT_RCD;
          cnt_next   = ONE;
        end
      end
      WAIT_RCD: begin
        if (cnt == RCD_LAST) state_next = RW;
        else                 cnt_next   = cnt + ONE;
      end
      RW: begin
        sd_cmd     = is_read ? SD_READ : SD_WRITE;
        ba         = addr_q[24:23];
        a          = col_ap_addr(addr_q[9:0]);
        state_next = WAIT_DONE;
        cnt_next   = ONE;
      end
      WAIT_DONE: begin
        rd_window = is_read && (cnt >= RD_FIRST) && (cnt <= RD_LAST);
        wr_window = !is_read && (cnt <= WR_LAST);
        if (cnt == (is_read ? RD_END : WR_END)) state_next = IDLE;
        else                                    cnt_next   = cnt + ONE;
      end
      REF: begin
        sd_cmd   = SD_AREF;
        ref_busy = 1'b1;
        if (TRFC <= 1) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_RFC;
          cnt_next   = ONE;
        end
      end
      WAIT_RFC: begin
        ref_busy = 1'b1;
        if (cnt == RFC_LAST) state_next = IDLE;
        else                 cnt_next   = cnt + ONE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
